// File: rtl/seg7_scan_decoder.sv
// Observer for the multiplexed 7-segment scan bus.
// Rebuilds the displayed hex value one complete frame at a time.
module seg7_scan_decoder #(
  parameter int N_DIGITS      = 8,
  parameter int STABLE_CYCLES = 2,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            Segments,
  input  logic [N_DIGITS-1:0]   Anodes,
  output logic [4*N_DIGITS-1:0] Value,
  output logic [N_DIGITS-1:0]   DigitValid,
  output logic [N_DIGITS-1:0]   Blank,
  output logic                  FrameValid,
  output logic                  Error
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_MAX = CW'(STABLE_CYCLES);
  localparam logic [N_DIGITS-1:0] A_ONE = N_DIGITS'(1);

  // {valid, blank, nibble}
  function automatic logic [5:0] f_decode(input logic [6:0] p);
    case (p)
      7'h3F:   f_decode = {2'b10, 4'h0};
      7'h06:   f_decode = {2'b10, 4'h1};
      7'h5B:   f_decode = {2'b10, 4'h2};
      7'h4F:   f_decode = {2'b10, 4'h3};
      7'h66:   f_decode = {2'b10, 4'h4};
      7'h6D:   f_decode = {2'b10, 4'h5};
      7'h7D:   f_decode = {2'b10, 4'h6};
      7'h07:   f_decode = {2'b10, 4'h7};
      7'h7F:   f_decode = {2'b10, 4'h8};
      7'h6F:   f_decode = {2'b10, 4'h9};
      7'h77:   f_decode = {2'b10, 4'hA};
      7'h7C:   f_decode = {2'b10, 4'hB};
      7'h39:   f_decode = {2'b10, 4'hC};
      7'h5E:   f_decode = {2'b10, 4'hD};
      7'h79:   f_decode = {2'b10, 4'hE};
      7'h71:   f_decode = {2'b10, 4'hF};
      7'h00:   f_decode = {2'b01, 4'h0};
      default: f_decode = 6'b0;
    endcase
  endfunction

  logic [N_DIGITS-1:0]   r_an;
  logic [6:0]            r_p;
  logic [CW-1:0]         r_cnt;
  logic [4*N_DIGITS-1:0] r_sh_val;
  logic [N_DIGITS-1:0]   r_sh_dv;
  logic [N_DIGITS-1:0]   r_sh_bl;
  logic [N_DIGITS-1:0]   r_seen;
  logic [4*N_DIGITS-1:0] r_value;
  logic [N_DIGITS-1:0]   r_dv;
  logic [N_DIGITS-1:0]   r_bl;
  logic                  r_fv;
  logic                  r_err;

  logic [N_DIGITS-1:0]   w_an;
  logic [6:0]            w_p;
  logic                  w_any;
  logic                  w_one;
  logic                  w_multi;
  logic                  w_match;
  logic                  w_sat;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  w_cap;
  logic [IW-1:0]         w_idx;
  logic [5:0]            w_dec;
  logic [4*N_DIGITS-1:0] w_sh_val;
  logic [N_DIGITS-1:0]   w_sh_dv;
  logic [N_DIGITS-1:0]   w_sh_bl;
  logic [N_DIGITS-1:0]   w_seen;
  logic                  w_frame;
  logic                  w_err;

  assign w_an    = ACTIVE_LOW ? ~Anodes : Anodes;
  assign w_p     = ACTIVE_LOW ? ~Segments : Segments;
  assign w_any   = |w_an;
  assign w_one   = w_any && ((w_an & (w_an - A_ONE)) == '0);
  assign w_multi = w_any && !w_one;

  // The counter saturates so a steady dwell captures exactly once.
  assign w_match   = (r_cnt != '0) && (w_an == r_an) && (w_p == r_p);
  assign w_sat     = (r_cnt == C_MAX);
  assign w_cnt_nxt = w_match ? (w_sat ? r_cnt : r_cnt + C_ONE) : C_ONE;
  assign w_cap     = w_one && (w_cnt_nxt == C_MAX) && !(w_match && w_sat);
  assign w_dec     = f_decode(w_p);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_DIGITS; i++)
      if (w_an[i]) w_idx = IW'(i);
  end

  always_comb begin
    w_sh_val = r_sh_val;
    w_sh_dv  = r_sh_dv;
    w_sh_bl  = r_sh_bl;
    w_seen   = r_seen;
    if (w_cap) begin
      w_sh_val[{w_idx, 2'b00} +: 4] = w_dec[3:0];
      w_sh_dv[w_idx] = w_dec[5];
      w_sh_bl[w_idx] = w_dec[4];
      w_seen = r_seen | w_an;
    end
  end

  assign w_frame = w_cap && (&w_seen);
  assign w_err   = w_multi || (w_cap && !w_dec[5] && !w_dec[4]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an     <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_sh_val <= '0;
      r_sh_dv  <= '0;
      r_sh_bl  <= '0;
      r_seen   <= '0;
      r_value  <= '0;
      r_dv     <= '0;
      r_bl     <= '0;
      r_fv     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_one) begin
        r_cnt <= w_cnt_nxt;
        r_an  <= w_an;
        r_p   <= w_p;
      end else begin
        r_cnt <= '0;
      end
      r_sh_val <= w_sh_val;
      r_sh_dv  <= w_sh_dv;
      r_sh_bl  <= w_sh_bl;
      r_seen   <= w_frame ? '0 : w_seen;
      r_fv     <= w_frame;
      r_err    <= w_err;
      if (w_frame) begin
        r_value <= w_sh_val;
        r_dv    <= w_sh_dv;
        r_bl    <= w_sh_bl;
      end
    end
  end

  assign Value      = r_value;
  assign DigitValid = r_dv;
  assign Blank      = r_bl;
  assign FrameValid = r_fv;
  assign Error      = r_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder.
// Active-low scan, STABLE_CYCLES=2, eight digits.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  Segments;
  logic [7:0]  Anodes;
  logic [31:0] Value;
  logic [7:0]  DigitValid;
  logic [7:0]  Blank;
  logic        FrameValid;
  logic        Error;

  int checks = 0;
  int errors = 0;
  int fv_n = 0;
  int err_n = 0;
  int f0;
  int e0;

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .N_DIGITS(8),
    .STABLE_CYCLES(2),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Segments(Segments),
    .Anodes(Anodes),
    .Value(Value),
    .DigitValid(DigitValid),
    .Blank(Blank),
    .FrameValid(FrameValid),
    .Error(Error)
  );

  always @(negedge clk) begin
    if (FrameValid) fv_n++;
    if (Error) err_n++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic show(input int d, input logic [6:0] p, input int n);
    Anodes   = ~(8'd1 << d);
    Segments = ~p;
    step(n);
  endtask

  task automatic gap(input int n);
    Anodes   = 8'hFF;
    Segments = 7'h7F;
    step(n);
  endtask

  initial begin
    reset    = 1'b1;
    Anodes   = 8'hFF;
    Segments = 7'h7F;

    // reset / idle
    step(3);
    chk("rst_value", Value, 32'h0);
    chk("rst_dv", 32'(DigitValid), 32'h0);
    chk("rst_blank", 32'(Blank), 32'h0);
    chk("rst_fv", 32'(FrameValid), 32'h0);
    chk("rst_err", 32'(Error), 32'h0);
    reset = 1'b0;
    gap(4);
    chk("idle_fv_cnt", fv_n, 0);
    chk("idle_err_cnt", err_n, 0);

    // basic frame 0,0,0,0,0,0,2,A
    f0 = fv_n;
    for (int d = 0; d < 6; d++) show(d, glyph[0], 4);
    show(6, glyph[2], 4);
    Anodes   = ~8'h80;
    Segments = ~glyph[10];
    step(1);
    chk("basic_fv_early", 32'(FrameValid), 32'h0);
    step(1);
    chk("basic_fv_pulse", 32'(FrameValid), 32'h1);
    step(1);
    chk("basic_fv_drop", 32'(FrameValid), 32'h0);
    step(1);
    gap(2);
    chk("basic_fv_cnt", fv_n - f0, 1);
    chk("basic_value", Value, 32'hA2000000);
    chk("basic_dv", 32'(DigitValid), 32'hFF);
    chk("basic_blank", 32'(Blank), 32'h00);
    chk("basic_err_cnt", err_n, 0);

    // glitch on digit 3
    f0 = fv_n;
    for (int d = 0; d < 3; d++) show(d, glyph[d], 3);
    show(3, glyph[3], 1);
    for (int d = 4; d < 8; d++) show(d, glyph[d], 3);
    gap(2);
    chk("glitch_no_frame", fv_n - f0, 0);
    chk("glitch_hold", Value, 32'hA2000000);
    show(3, glyph[3], 3);
    gap(2);
    chk("glitch_frame", fv_n - f0, 1);
    chk("glitch_value", Value, 32'h76543210);

    // blank digit 7, bad glyph on digit 5
    f0 = fv_n;
    e0 = err_n;
    for (int d = 0; d < 5; d++) show(d, glyph[d], 3);
    show(5, 7'h7E, 3);
    show(6, glyph[6], 3);
    show(7, 7'h00, 3);
    gap(2);
    chk("bad_err_cnt", err_n - e0, 1);
    chk("bad_fv_cnt", fv_n - f0, 1);
    chk("bad_value", Value, 32'h06043210);
    chk("bad_dv", 32'(DigitValid), 32'h5F);
    chk("bad_blank", 32'(Blank), 32'h80);

    // multi-anode fault in the middle of a frame
    f0 = fv_n;
    e0 = err_n;
    for (int d = 0; d < 4; d++) show(d, glyph[8 + d], 3);
    Anodes   = 8'b1111_1100;
    Segments = ~glyph[1];
    step(5);
    for (int d = 4; d < 8; d++) show(d, glyph[8 + d], 3);
    gap(2);
    chk("multi_err_cnt", err_n - e0, 5);
    chk("multi_fv_cnt", fv_n - f0, 1);
    chk("multi_value", Value, 32'hFEDCBA98);

    // wrap-around rescan of digit 0
    f0 = fv_n;
    for (int d = 0; d < 4; d++) show(d, glyph[d + 1], 3);
    show(0, glyph[9], 3);
    for (int d = 4; d < 8; d++) show(d, glyph[0], 3);
    gap(2);
    chk("wrap_fv_cnt", fv_n - f0, 1);
    chk("wrap_nib0", 32'(Value[3:0]), 32'h9);
    chk("wrap_value", Value, 32'h00004329);

    // reset mid-frame
    f0 = fv_n;
    for (int d = 0; d < 6; d++) show(d, glyph[5], 3);
    Anodes = 8'hFF;
    reset  = 1'b1;
    step(2);
    reset  = 1'b0;
    chk("mid_rst_value", Value, 32'h0);
    chk("mid_rst_fv", 32'(FrameValid), 32'h0);
    for (int d = 0; d < 7; d++) show(d, glyph[1], 3);
    chk("mid_no_frame", fv_n - f0, 0);
    show(7, glyph[2], 3);
    gap(2);
    chk("mid_frame", fv_n - f0, 1);
    chk("mid_value", Value, 32'h21111111);
    chk("mid_dv", 32'(DigitValid), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
